muldiv_seq: RTL and testbench

//  Iterative multiply/divide unit owning the HI/LO register pair; the sequential replacement for the ALU's combinational mult/div path.

---
 rtl/muldiv_pkg.sv | 16 +
 rtl/muldiv_if.sv | 31 +++
 rtl/muldiv_sign_fix.sv | 58 +++++
 rtl/muldiv_seq.sv | 213 +++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 6;

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the pipeline and muldiv_seq.
// MULDIV_DIVZERO_EXC_EN adds the dz divide-by-zero pulse.
interface muldiv_if import muldiv_pkg::*; #(parameter int WIDTH = DEF_WIDTH) ();

    logic             start;
    logic             op;
    logic             sign;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
`ifdef MULDIV_DIVZERO_EXC_EN
    logic             dz;

    modport master (output start, op, sign, A, B, mthi, mtlo, wdata,
                    input  hi, lo, busy, done, dz);
    modport slave  (input  start, op, sign, A, B, mthi, mtlo, wdata,
                    output hi, lo, busy, done, dz);
`else
    modport master (output start, op, sign, A, B, mthi, mtlo, wdata,
                    input  hi, lo, busy, done);
    modport slave  (input  start, op, sign, A, B, mthi, mtlo, wdata,
                    output hi, lo, busy, done);
`endif

endinterface

// File: rtl/muldiv_sign_fix.sv
// Combinational sign handling: operand magnitudes on load, result negation on FIX.
module muldiv_sign_fix import muldiv_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             i_sign,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_abs_a,
    output logic [WIDTH-1:0] o_abs_b,
    output logic             o_res_neg,
    output logic             o_rem_neg,
    input  logic             i_op,
    input  logic             i_fix_res_neg,
    input  logic             i_fix_rem_neg,
    input  logic [WIDTH-1:0] i_hi_mag,
    input  logic [WIDTH-1:0] i_lo_mag,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + ONE_W;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return ~v + ONE_2W;
    endfunction

    logic [2*WIDTH-1:0] w_prod_neg;

    assign o_abs_a    = (i_sign && i_a[WIDTH-1]) ? neg_w(i_a) : i_a;
    assign o_abs_b    = (i_sign && i_b[WIDTH-1]) ? neg_w(i_b) : i_b;
    assign o_res_neg  = i_sign & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
    assign o_rem_neg  = i_sign & i_a[WIDTH-1];
    assign w_prod_neg = neg_2w({i_hi_mag, i_lo_mag});

    // Product negates as one 2*WIDTH value; quotient and remainder negate independently
    always_comb begin
        o_hi = i_hi_mag;
        o_lo = i_lo_mag;
        if (i_op == OP_MULT) begin
            if (i_fix_res_neg) begin
                o_hi = w_prod_neg[2*WIDTH-1:WIDTH];
                o_lo = w_prod_neg[WIDTH-1:0];
            end else begin
                o_hi = i_hi_mag;
                o_lo = i_lo_mag;
            end
        end else begin
            o_hi = i_fix_rem_neg ? neg_w(i_hi_mag) : i_hi_mag;
            o_lo = i_fix_res_neg ? neg_w(i_lo_mag) : i_lo_mag;
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide unit owning HI/LO; one shift-add/subtract step per cycle.
// MULDIV_DIVZERO_EXC_EN: divide by zero skips CALC and pulses dz with done.
module muldiv_seq import muldiv_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic    clk,
    input  logic    reset,
    muldiv_if.slave bus
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_b;
    logic               r_op;
    logic               r_res_neg;
    logic               r_rem_neg;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;

    logic               w_load;
    logic               w_step;
    logic               w_write;
    logic               w_idle;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic               w_res_neg;
    logic               w_rem_neg;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;
    logic [WIDTH:0]     w_msum;
    logic [WIDTH:0]     w_dshift;
    logic [WIDTH:0]     w_ddiff;
    logic               w_last;

`ifdef MULDIV_DIVZERO_EXC_EN
    logic               r_divz;
    logic               r_dz;
    logic               w_divz;

    assign w_divz = (bus.op == OP_DIV) && (bus.B == '0);
    assign bus.dz = r_dz;
`endif

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .i_sign        (bus.sign),
        .i_a           (bus.A),
        .i_b           (bus.B),
        .o_abs_a       (w_abs_a),
        .o_abs_b       (w_abs_b),
        .o_res_neg     (w_res_neg),
        .o_rem_neg     (w_rem_neg),
        .i_op          (r_op),
        .i_fix_res_neg (r_res_neg),
        .i_fix_rem_neg (r_rem_neg),
        .i_hi_mag      (r_rem),
        .i_lo_mag      (r_q),
        .o_hi          (w_fix_hi),
        .o_lo          (w_fix_lo)
    );

    // Multiply: {r_rem,r_q} is the product register, multiplier bits consumed from r_q[0]
    assign w_msum   = {1'b0, r_rem} + (r_q[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    // Divide: restoring step, dividend bits shifted out of r_q as quotient bits shift in
    assign w_dshift = {r_rem, r_q[WIDTH-1]};
    assign w_ddiff  = w_dshift - {1'b0, r_b};
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
`ifdef MULDIV_DIVZERO_EXC_EN
                    w_state_nxt = w_divz ? FIX : CALC;
`else
                    w_state_nxt = CALC;
`endif
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_state_nxt = FIX;
                end else begin
                    w_state_nxt = CALC;
                end
            end
            FIX:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Per-state datapath strobes
    always_comb begin
        w_idle  = (r_state == IDLE);
        w_load  = 1'b0;
        w_step  = (r_state == CALC);
        w_write = 1'b0;
        if (w_idle) begin
            w_load = bus.start;
        end else begin
            w_load = 1'b0;
        end
        if (r_state == FIX) begin
`ifdef MULDIV_DIVZERO_EXC_EN
            w_write = ~r_divz;
`else
            w_write = 1'b1;
`endif
        end else begin
            w_write = 1'b0;
        end
    end

    // Operand latch and iteration datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_q       <= '0;
            r_b       <= '0;
            r_op      <= OP_MULT;
            r_res_neg <= 1'b0;
            r_rem_neg <= 1'b0;
        end else if (w_load) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_q       <= w_abs_a;
            r_b       <= w_abs_b;
            r_op      <= bus.op;
            r_res_neg <= w_res_neg;
            r_rem_neg <= w_rem_neg;
        end else if (w_step) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_op == OP_MULT) begin
                r_rem <= w_msum[WIDTH:1];
                r_q   <= {w_msum[0], r_q[WIDTH-1:1]};
            end else if (!w_ddiff[WIDTH]) begin
                r_rem <= w_ddiff[WIDTH-1:0];
                r_q   <= {r_q[WIDTH-2:0], 1'b1};
            end else begin
                r_rem <= w_dshift[WIDTH-1:0];
                r_q   <= {r_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // HI/LO: op results in FIX, MTHI/MTLO only while idle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_write) begin
            r_hi <= w_fix_hi;
            r_lo <= w_fix_lo;
        end else if (w_idle) begin
            r_hi <= bus.mthi ? bus.wdata : r_hi;
            r_lo <= bus.mtlo ? bus.wdata : r_lo;
        end else begin
            r_hi <= r_hi;
            r_lo <= r_lo;
        end
    end

    // Status outputs; done lands on the same edge as the HI/LO update
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != IDLE);
            r_done <= (r_state == FIX);
        end
    end

`ifdef MULDIV_DIVZERO_EXC_EN
    // Divide-by-zero flag follows the op through FIX
    always_ff @(posedge clk) begin
        if (reset) begin
            r_divz <= 1'b0;
            r_dz   <= 1'b0;
        end else begin
            r_divz <= w_load ? w_divz : r_divz;
            r_dz   <= (r_state == FIX) && r_divz;
        end
    end
`endif

    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq (honours MULDIV_DIVZERO_EXC_EN).
module tb_muldiv_seq;
    import muldiv_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one op; lat = edges from start-sample to done (-1 on timeout)
    task automatic run_op(input logic op_i, input logic sign_i,
                          input logic [31:0] a_i, input logic [31:0] b_i,
                          output int lat, output logic busy0);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op_i; bus.sign = sign_i; bus.A = a_i; bus.B = b_i;
        @(posedge clk); #1;
        bus.start = 1'b0;
        busy0 = bus.busy;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic check_op(input string name, input logic op_i, input logic sign_i,
                            input logic [31:0] a_i, input logic [31:0] b_i,
                            input int exp_lat, input logic [31:0] exp_hi,
                            input logic [31:0] exp_lo);
        int   lat;
        logic busy0;
        run_op(op_i, sign_i, a_i, b_i, lat, busy0);
        n_checks += 4;
        if (lat !== exp_lat) $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        else n_pass++;
        if (busy0 !== 1'b1) $display("FAIL %s busy: got %b expected 1", name, busy0);
        else n_pass++;
        if (bus.hi !== exp_hi) $display("FAIL %s hi: got %h expected %h", name, bus.hi, exp_hi);
        else n_pass++;
        if (bus.lo !== exp_lo) $display("FAIL %s lo: got %h expected %h", name, bus.lo, exp_lo);
        else n_pass++;
        @(posedge clk); #1;
        n_checks += 2;
        if (bus.done !== 1'b0) $display("FAIL %s done_pulse: got %b expected 0", name, bus.done);
        else n_pass++;
        if (bus.busy !== 1'b0) $display("FAIL %s busy_idle: got %b expected 0", name, bus.busy);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        n_checks += 4;
        if (bus.hi !== 32'h0) $display("FAIL reset_hi: got %h expected 0", bus.hi); else n_pass++;
        if (bus.lo !== 32'h0) $display("FAIL reset_lo: got %h expected 0", bus.lo); else n_pass++;
        if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else n_pass++;
        if (bus.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus.done); else n_pass++;
    endtask

    task automatic test_arith();
        check_op("umul_max", OP_MULT, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE, 32'h00000001);
        check_op("smul_m3x7", OP_MULT, 1'b1, 32'hFFFFFFFD, 32'd7, 33, 32'hFFFFFFFF, 32'hFFFFFFEB);
        check_op("udiv_100_7", OP_DIV, 1'b0, 32'd100, 32'd7, 33, 32'd2, 32'd14);
        check_op("sdiv_m7_2", OP_DIV, 1'b1, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
        check_op("sdiv_min_m1", OP_DIV, 1'b1, 32'h80000000, 32'hFFFFFFFF, 33, 32'h0, 32'h80000000);
        check_op("smul_m4xm5", OP_MULT, 1'b1, 32'hFFFFFFFC, 32'hFFFFFFFB, 33, 32'h0, 32'd20);
    endtask

    task automatic test_mt();
        @(negedge clk);
        bus.mtlo = 1'b1; bus.wdata = 32'h1234;
        @(posedge clk); #1;
        bus.mtlo = 1'b0;
        n_checks += 1;
        if (bus.lo !== 32'h1234) $display("FAIL mtlo: got %h expected 00001234", bus.lo); else n_pass++;
        @(negedge clk);
        bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'hCAFE0001;
        @(posedge clk); #1;
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
        n_checks += 2;
        if (bus.hi !== 32'hCAFE0001) $display("FAIL mt_both_hi: got %h expected cafe0001", bus.hi); else n_pass++;
        if (bus.lo !== 32'hCAFE0001) $display("FAIL mt_both_lo: got %h expected cafe0001", bus.lo); else n_pass++;
    endtask

    task automatic test_start_with_mthi();
        int lat;
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MULT; bus.sign = 1'b0; bus.A = 32'd2; bus.B = 32'd3;
        bus.mthi = 1'b1; bus.wdata = 32'hAA;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.mthi = 1'b0;
        n_checks += 1;
        if (bus.hi !== 32'hAA) $display("FAIL start_mthi_hi: got %h expected 000000aa", bus.hi); else n_pass++;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (bus.done) begin lat = k; break; end
        end
        n_checks += 3;
        if (lat !== 33) $display("FAIL start_mthi_lat: got %0d expected 33", lat); else n_pass++;
        if (bus.hi !== 32'h0) $display("FAIL start_mthi_res_hi: got %h expected 0", bus.hi); else n_pass++;
        if (bus.lo !== 32'd6) $display("FAIL start_mthi_res_lo: got %h expected 6", bus.lo); else n_pass++;
    endtask

    task automatic test_busy_ignore();
        int dones;
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MULT; bus.sign = 1'b0; bus.A = 32'd3; bus.B = 32'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_DIV; bus.A = 32'd100; bus.B = 32'd7;
        bus.mthi = 1'b1; bus.wdata = 32'h55;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.mthi = 1'b0;
        dones = 0;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        n_checks += 3;
        if (dones !== 1) $display("FAIL busy_ignore_dones: got %0d expected 1", dones); else n_pass++;
        if (bus.hi !== 32'h0) $display("FAIL busy_ignore_hi: got %h expected 0", bus.hi); else n_pass++;
        if (bus.lo !== 32'd15) $display("FAIL busy_ignore_lo: got %h expected f", bus.lo); else n_pass++;
    endtask

    task automatic test_reset_midop();
        int dones;
        @(negedge clk);
        bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'h77;
        @(negedge clk);
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
        bus.start = 1'b1; bus.op = OP_MULT; bus.sign = 1'b0; bus.A = 32'd9; bus.B = 32'd9;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_checks += 3;
        if (bus.hi !== 32'h0) $display("FAIL midreset_hi: got %h expected 0", bus.hi); else n_pass++;
        if (bus.lo !== 32'h0) $display("FAIL midreset_lo: got %h expected 0", bus.lo); else n_pass++;
        if (bus.busy !== 1'b0) $display("FAIL midreset_busy: got %b expected 0", bus.busy); else n_pass++;
        dones = 0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        n_checks += 1;
        if (dones !== 0) $display("FAIL midreset_done: got %0d expected 0", dones); else n_pass++;
    endtask

    task automatic test_divzero();
`ifdef MULDIV_DIVZERO_EXC_EN
        int   lat;
        logic busy0;
        @(negedge clk);
        bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'h0BAD0BAD;
        @(negedge clk);
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
        run_op(OP_DIV, 1'b0, 32'd5, 32'd0, lat, busy0);
        n_checks += 4;
        if (lat !== 1) $display("FAIL dz_latency: got %0d expected 1", lat); else n_pass++;
        if (bus.dz !== 1'b1) $display("FAIL dz_flag: got %b expected 1", bus.dz); else n_pass++;
        if (bus.hi !== 32'h0BAD0BAD) $display("FAIL dz_hi: got %h expected 0bad0bad", bus.hi); else n_pass++;
        if (bus.lo !== 32'h0BAD0BAD) $display("FAIL dz_lo: got %h expected 0bad0bad", bus.lo); else n_pass++;
        @(posedge clk); #1;
        n_checks += 2;
        if (bus.dz !== 1'b0) $display("FAIL dz_pulse: got %b expected 0", bus.dz); else n_pass++;
        if (bus.done !== 1'b0) $display("FAIL dz_done_pulse: got %b expected 0", bus.done); else n_pass++;
        check_op("udiv_after_dz", OP_DIV, 1'b0, 32'd100, 32'd7, 33, 32'd2, 32'd14);
`else
        check_op("udiv_5_0", OP_DIV, 1'b0, 32'd5, 32'd0, 33, 32'd5, 32'hFFFFFFFF);
        check_op("sdiv_m5_0", OP_DIV, 1'b1, 32'hFFFFFFFB, 32'd0, 33, 32'hFFFFFFFB, 32'h00000001);
        check_op("sdiv_5_0", OP_DIV, 1'b1, 32'd5, 32'd0, 33, 32'd5, 32'hFFFFFFFF);
`endif
    endtask

    task automatic test_back_to_back();
        int   lat;
        logic busy0;
        run_op(OP_MULT, 1'b0, 32'h00010000, 32'h00010000, lat, busy0);
        run_op(OP_DIV, 1'b0, 32'd1000, 32'd10, lat, busy0);
        n_checks += 3;
        if (lat !== 33) $display("FAIL b2b_latency: got %0d expected 33", lat); else n_pass++;
        if (bus.hi !== 32'd0) $display("FAIL b2b_hi: got %h expected 0", bus.hi); else n_pass++;
        if (bus.lo !== 32'd100) $display("FAIL b2b_lo: got %h expected 64", bus.lo); else n_pass++;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = OP_MULT;
        bus.sign  = 1'b0;
        bus.A     = 32'h0;
        bus.B     = 32'h0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.wdata = 32'h0;
        test_reset();
        test_arith();
        test_mt();
        test_start_with_mthi();
        test_busy_ignore();
        test_reset_midop();
        test_divzero();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
